// File: rtl/bm_dag_descrambler_pkg.sv
// bm_dag_descrambler_pkg: shared widths and tap positions for the x^7+x^6+1 descrambler
package bm_dag_descrambler_pkg;
    localparam int BITS   = 2;
    localparam int SR_LEN = 7;
    localparam int TAP_A  = 5;
    localparam int TAP_B  = 6;
endpackage

// File: rtl/bm_dag_descrambler_if.sv
// bm_dag_descrambler_if: stream bus of the descrambler.
// Inputs to the block: sync_clear, valid_in, data_in[BITS].
// Outputs from the block: valid_out, data_out[BITS], locked.
interface bm_dag_descrambler_if;
    import bm_dag_descrambler_pkg::*;
    logic            sync_clear;
    logic            valid_in;
    logic [BITS-1:0] data_in;
    logic            valid_out;
    logic [BITS-1:0] data_out;
    logic            locked;
    modport master (output sync_clear, valid_in, data_in, input valid_out, data_out, locked);
    modport slave  (input sync_clear, valid_in, data_in, output valid_out, data_out, locked);
endinterface

// File: rtl/bm_dag_descrambler_descr_step.sv
// bm_dag_descrambler_descr_step: one combinational descrambling step for a single received bit.
// s_i: history before the bit (s_i[0] newest); r_i: received bit;
// d_o: descrambled bit; s_o: history with r_i shifted in.
module bm_dag_descrambler_descr_step
    import bm_dag_descrambler_pkg::*;
(
    input  logic [SR_LEN-1:0] s_i,
    input  logic              r_i,
    output logic              d_o,
    output logic [SR_LEN-1:0] s_o
);
    assign d_o = r_i ^ s_i[TAP_A] ^ s_i[TAP_B];
    assign s_o = {s_i[SR_LEN-2:0], r_i};
endmodule

// File: rtl/bm_dag_descrambler.sv
// bm_dag_descrambler: self-synchronizing x^7+x^6+1 descrambler, BITS bits per word, MSB first.
// clock/reset: rising-edge clock, async active-high reset.
// bus (slave): sync_clear, valid_in, data_in in; valid_out, data_out, locked out (all registered).
module bm_dag_descrambler
    import bm_dag_descrambler_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    bm_dag_descrambler_if.slave     bus
);
    logic [SR_LEN-1:0] s_q, s_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        cnt_sum;
    logic [BITS-1:0]   data_q, d_word;
    logic              valid_q, locked_q, accept;
    logic [SR_LEN-1:0] s_chain [0:BITS];

    assign s_chain[0] = s_q;

    // Bit BITS-1 goes through the first stage; each stage feeds its history to the next.
    for (genvar i = 0; i < BITS; i++) begin : g_step
        bm_dag_descrambler_descr_step u_step (
            .s_i (s_chain[i]),
            .r_i (bus.data_in[BITS-1-i]),
            .d_o (d_word[BITS-1-i]),
            .s_o (s_chain[i+1])
        );
    end

    assign accept  = bus.valid_in & ~bus.sync_clear;
    assign cnt_sum = {1'b0, cnt_q} + 4'(BITS);

    always_comb begin
        s_d   = bus.sync_clear ? '0 : accept ? s_chain[BITS] : s_q;
        cnt_d = bus.sync_clear ? 3'd0 :
                accept ? (cnt_sum > 4'(SR_LEN) ? 3'(SR_LEN) : cnt_sum[2:0]) : cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_q      <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            valid_q  <= accept;
            locked_q <= cnt_d == 3'(SR_LEN);
            if (accept)
                data_q <= d_word;
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.locked    = locked_q;
endmodule
